// File: rtl/ifu_pkg.sv
// ifu_pkg: fetch-unit states, MIPS instruction field ranges and
// default PC vectors shared by ifu_pipe and ifu_npc.
package ifu_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } ifu_state_e;

  localparam int OP_HI    = 31;
  localparam int OP_LO    = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int IMM16_HI = 15;
  localparam int IMM16_LO = 0;
  localparam int IMM26_HI = 25;
  localparam int IMM26_LO = 0;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_PC_DEF   = 32'h0000_4180;

endpackage

// File: rtl/ifu_npc.sv
// ifu_npc: decode-stage redirect target (jr > j > branch)
// computed from the IF/ID instruction and PC.
module ifu_npc
  import ifu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [31:0]       instr_i,
  input  logic              br_taken_i,
  input  logic              j_i,
  input  logic              jr_i,
  input  logic [ADDR_W-1:0] jr_target_i,
  output logic              redir_o,
  output logic [ADDR_W-1:0] target_o
);

  logic [15:0]       imm16;
  logic [25:0]       imm26;
  logic [ADDR_W-1:0] br_off;
  logic              unused_fields;

  assign imm16  = instr_i[IMM16_HI:IMM16_LO];
  assign imm26  = instr_i[IMM26_HI:IMM26_LO];
  assign br_off = {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};

  // register fields do not affect the target
  assign unused_fields = ^{instr_i[OP_HI:OP_LO], instr_i[RS_HI:RS_LO],
                           instr_i[RT_HI:RT_LO], instr_i[RD_HI:RD_LO]};

  assign redir_o = br_taken_i || j_i || jr_i;

  always_comb begin
    target_o = pc_i + ADDR_W'(4) + br_off;
    if (jr_i) begin
      target_o = jr_target_i;
    end else if (j_i) begin
      target_o = {pc_i[ADDR_W-1:28], imm26, 2'b00};
    end
  end

endmodule

// File: rtl/ifu_pipe.sv
// ifu_pipe: fetch PC, imem req/gnt/rvalid handshake and IF/ID register.
// Define IFU_DELAY_SLOT_EN for delay-slot redirects; default build flushes.
module ifu_pipe
  import ifu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter logic [ADDR_W-1:0] EXC_PC   = ADDR_W'(EXC_PC_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              stall_d,
  input  logic              br_taken,
  input  logic              j,
  input  logic              jr,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic              exc_req,
  output logic [31:0]       instr_d,
  output logic [ADDR_W-1:0] pc_d,
  output logic [ADDR_W-1:0] pc8_d,
  output logic              valid_d,
  output logic              fetch_busy
);

`ifdef IFU_DELAY_SLOT_EN
  localparam bit DS_EN = 1'b1;
`else
  localparam bit DS_EN = 1'b0;
`endif

  ifu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_f_q, pc_f_d;
  logic              discard_q, discard_d;
  logic [31:0]       buf_q, buf_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  logic [31:0]       ifid_instr_q, ifid_instr_d;
  logic [ADDR_W-1:0] ifid_pc_q, ifid_pc_d;
  logic [ADDR_W-1:0] ifid_pc8_q, ifid_pc8_d;
  logic              ifid_vld_q, ifid_vld_d;

  logic              npc_redir;
  logic              redir;
  logic              flush;
  logic              deliver;
  logic [ADDR_W-1:0] npc_tgt;
  logic [ADDR_W-1:0] flush_pc;
  logic [ADDR_W-1:0] adv_pc;
  logic [31:0]       dl_instr;

  ifu_npc #(
    .ADDR_W(ADDR_W)
  ) u_npc (
    .pc_i       (ifid_pc_q),
    .instr_i    (ifid_instr_q),
    .br_taken_i (br_taken),
    .j_i        (j),
    .jr_i       (jr),
    .jr_target_i(jr_target),
    .redir_o    (npc_redir),
    .target_o   (npc_tgt)
  );

  assign redir    = ifid_vld_q && !stall_d && npc_redir;
  assign flush    = exc_req || (redir && !DS_EN);
  assign flush_pc = exc_req ? EXC_PC : npc_tgt;
  assign adv_pc   = (DS_EN && redir) ? npc_tgt :
                    pend_q ? pend_tgt_q : pc_f_q + ADDR_W'(4);

  assign imem_req   = reset && (state_q == REQ);
  assign imem_addr  = pc_f_q;
  assign fetch_busy = imem_req || (state_q == WAIT);
  assign instr_d    = ifid_instr_q;
  assign pc_d       = ifid_pc_q;
  assign pc8_d      = ifid_pc8_q;
  assign valid_d    = ifid_vld_q;

  always_comb begin
    state_d      = state_q;
    pc_f_d       = pc_f_q;
    discard_d    = discard_q;
    buf_d        = buf_q;
    pend_d       = pend_q;
    pend_tgt_d   = pend_tgt_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc8_d   = ifid_pc8_q;
    ifid_vld_d   = stall_d ? ifid_vld_q : 1'b0;
    deliver      = 1'b0;
    dl_instr     = imem_rdata;

    unique case (state_q)
      REQ: begin
        if (imem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d = REQ;
          if (discard_q) begin
            discard_d = 1'b0;
          end else if (!stall_d) begin
            deliver = 1'b1;
          end else begin
            buf_d   = imem_rdata;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (!stall_d) begin
          deliver  = 1'b1;
          dl_instr = buf_q;
          state_d  = REQ;
        end
      end
      default: state_d = REQ;
    endcase

    if (deliver && !flush) begin
      ifid_instr_d = dl_instr;
      ifid_pc_d    = pc_f_q;
      ifid_pc8_d   = pc_f_q + ADDR_W'(8);
      ifid_vld_d   = 1'b1;
      pc_f_d       = adv_pc;
      pend_d       = 1'b0;
    end

    // delay slot still to come: remember where to go after it
    if (DS_EN && redir && !deliver) begin
      pend_d     = 1'b1;
      pend_tgt_d = npc_tgt;
    end

    if (flush) begin
      pc_f_d     = flush_pc;
      ifid_vld_d = 1'b0;
      buf_d      = '0;
      pend_d     = 1'b0;
      unique case (state_q)
        REQ:     discard_d = imem_gnt;
        WAIT:    discard_d = !imem_rvalid;
        HOLD:    state_d   = REQ;
        default: state_d   = REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= REQ;
      pc_f_q       <= RESET_PC;
      discard_q    <= 1'b0;
      buf_q        <= '0;
      pend_q       <= 1'b0;
      pend_tgt_q   <= '0;
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
      ifid_pc8_q   <= ADDR_W'(8);
      ifid_vld_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_f_q       <= pc_f_d;
      discard_q    <= discard_d;
      buf_q        <= buf_d;
      pend_q       <= pend_d;
      pend_tgt_q   <= pend_tgt_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc8_q   <= ifid_pc8_d;
      ifid_vld_q   <= ifid_vld_d;
    end
  end

endmodule

// File: doc/ifu_pipe.md
Name: ifu_pipe

Overview:
Parametrised instruction-fetch unit for the pipelined CPU. It replaces the single-cycle PC/NPC/IM path.
- Holds the fetch PC and issues requests to a variable-latency instruction memory over a req/gnt/rvalid handshake.
- Buffers one returned instruction under stall and drives the IF/ID pipeline register.
- Resolves branch, j and jr redirects from decode, and exception redirects.

Parameters:
ADDR_W, 32, PC and address width
RESET_PC, 32'h0000_3000, fetch PC after reset
EXC_PC, 32'h0000_4180, exception vector

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
imem_req  out  1  fetch request valid
imem_addr  out  ADDR_W  fetch address (word aligned)
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  read data valid; at least 1 cycle after gnt
imem_rdata  in  32  instruction word
stall_d  in  1  decode cannot accept; hold IF/ID
br_taken  in  1  decode-stage branch taken
j  in  1  decode-stage j/jal
jr  in  1  decode-stage jr/jalr
jr_target  in  ADDR_W  register target for jr
exc_req  in  1  exception/flush request, highest priority
instr_d  out  32  IF/ID instruction
pc_d  out  ADDR_W  IF/ID PC
pc8_d  out  ADDR_W  pc_d+8, link value
valid_d  out  1  IF/ID holds a live instruction
fetch_busy  out  1  request or response outstanding

Behaviour:
- Reset (reset=0, asynchronous):
  - pc_f=RESET_PC, state=REQ, imem_req=0.
  - instr_d=0, pc_d=0, pc8_d=8, valid_d=0.
  - Discard and redirect-pending flags cleared.
  - First request is issued the cycle after release.
- At most one outstanding fetch. imem_addr=pc_f, held stable while imem_req=1.
- State machine:
  - REQ: imem_req=1; on gnt go to WAIT.
  - WAIT: on rvalid with discard set, drop the data, clear discard, go to REQ. On rvalid with !stall_d, load IF/ID {rdata, pc_f, pc_f+8, valid=1}, advance pc_f, go to REQ. On rvalid with stall_d, capture into the buffer, go to HOLD.
  - HOLD: on !stall_d, load IF/ID from the buffer, advance pc_f, go to REQ.
- pc_f advance: normally pc_f+4. If a redirect is pending, use the target and clear the pending flag. Arithmetic is modulo 2^ADDR_W.
- Redirect is evaluated when valid_d && !stall_d && (br_taken|j|jr). Priority is jr > j > br.
  - br target: pc_d+4+(sext(imm16)<<2).
  - j target: {pc_d[ADDR_W-1:28], imm26, 2'b00}.
  - jr target: jr_target.
  - Handling depends on IFU_DELAY_SLOT_EN (below).
- When stall_d=1, IF/ID holds its contents and valid_d holds its value. Requests may still complete into the buffer.
- When !stall_d and no instruction is delivered this cycle, valid_d<=0 (bubble).
- exc_req (any state, any stall): on the next edge,
  - pc_f<=EXC_PC, valid_d<=0, buffer cleared, pending redirect cleared.
  - In WAIT, discard<=1. In HOLD, go to REQ. In REQ with no gnt, the address switches to EXC_PC the next cycle.
  - A gnt coinciding with exc_req sets discard.
- Simultaneous exc_req and redirect: exc_req wins.
- Simultaneous redirect and rvalid: the rvalid instruction is treated per delay-slot mode.
- A request not granted in REQ may change address only on exc_req or a non-delay-slot redirect.

Optional Feature:
IFU_DELAY_SLOT_EN
- Defined (MIPS delay slot): a redirect sets redirect-pending with the target. The in-flight or buffered instruction at pc_d+4 is delivered normally as the delay slot. The next pc_f is the target.
- Undefined: a redirect flushes immediately. pc_f<=target, valid_d<=0, discard<=1 if in WAIT, buffer cleared if in HOLD, REQ address switches.

Decomposition:
- Package ifu_pkg:
  - State enum {REQ, WAIT, HOLD}.
  - Field ranges OP, RS, RT, RD, IMM16, IMM26.
  - Defaults for RESET_PC and EXC_PC.
- One combinational sub-module ifu_npc computes the target and redirect valid from pc_d, instr_d, br_taken, j, jr and jr_target.

Test Plan:
- Reset, then gnt same cycle and rvalid 1 cycle later each fetch -> imem_addr 0x3000, 0x3004, 0x3008. valid_d=1 with pc_d=0x3000 and pc8_d=0x3008 two cycles after release.
- rvalid delayed 3 cycles -> imem_req=0 and fetch_busy=1 during the wait. IF/ID updates once per fetch; no duplicate addresses.
- stall_d held 4 cycles while the fetch at 0x3008 returns -> state HOLD. IF/ID holds 0x3004. 0x3008 is delivered on the first !stall_d cycle with no refetch.
- beq at 0x3004 with imm16=0x0003 taken:
  - IFU_DELAY_SLOT_EN defined -> 0x3008 is delivered, then fetch 0x3014.
  - Undefined -> 0x3008 is discarded, valid_d=0 for one cycle, then fetch 0x3014.
- jr with jr_target=0x3100 asserted together with exc_req -> pc_f=0x4180, valid_d=0, in-flight data dropped.
- reset asserted mid-WAIT -> all outputs take their reset values immediately. A stale rvalid arriving after release is ignored until a new gnt.
